// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Handshake and data bundle around the RV32I decode stage.
//                Fetch side:     in_valid / in_ready / instr / flush
//                Execute side:   out_valid / out_ready / decoded fields
//                Writeback side: wb_valid / wb_rd (retire events)
//                master = environment (fetch/execute/writeback),
//                slave  = decode_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_op;
    logic [2:0]      out_op_b;
    logic            out_sela;
    logic            out_selb;
    logic            out_we;
    logic [REGW-1:0] out_rd;
    logic [REGW-1:0] out_rs1;
    logic [REGW-1:0] out_rs2;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    logic            wb_valid;
    logic [REGW-1:0] wb_rd;

    modport master (
        output in_valid, instr, flush, out_ready, wb_valid, wb_rd,
        input  in_ready, out_valid, out_op, out_op_b, out_sela, out_selb,
               out_we, out_rd, out_rs1, out_rs2, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, instr, flush, out_ready, wb_valid, wb_rd,
        output in_ready, out_valid, out_op, out_op_b, out_sela, out_selb,
               out_we, out_rd, out_rs1, out_rs2, out_imm, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered RV32I decode stage with a one-entry pipeline
//                register, valid/ready handshakes on both sides, immediate
//                generation, illegal-instruction detection and a per-register
//                pending-write scoreboard that stalls read-after-write hazards.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - decode_stage_if.slave (fetch, execute, writeback)
//  Option      : DECODE_WB_BYPASS_EN - a same-cycle writeback is subtracted
//                from the scoreboard count used by the hazard check, so a
//                stalled instruction is released in the writeback cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int REGW     = 5,
    parameter int SB_CNT_W = 2
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    decode_stage_if.slave bus
);
    localparam int                  NSLOT   = 2 ** REGW;
    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0]         NREG_U  = NREG;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ARITHI = 7'b0010011;
    localparam logic [6:0] OPC_ARITHR = 7'b0110011;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4;
    localparam logic [3:0] OP_SRA = 4'd5;
    localparam logic [3:0] OP_SLU = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_AND = 4'd9;
    localparam logic [3:0] OP_XOR = 4'd10;
    localparam logic [3:0] OP_SIU = 4'd11;
    localparam logic [3:0] OP_AIU = 4'd12;

    localparam logic [2:0] BR_ZER = 3'd1;
    localparam logic [2:0] BR_NZR = 3'd2;
    localparam logic [2:0] BR_DAT = 3'd3;
    localparam logic [2:0] BR_NDT = 3'd4;
    localparam logic [2:0] BR_JMP = 3'd5;

    // ALU op shared by register and immediate arithmetic; alt is the
    // funct7=0100000 variant (SUB for funct3=000, SRA for funct3=101).
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLU;
            3'b100:  op = OP_XOR;
            3'b101:  op = alt ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [REGW-1:0] w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opc   = bus.instr[6:0];
    assign w_f3    = bus.instr[14:12];
    assign w_f7    = bus.instr[31:25];
    assign w_rd    = bus.instr[7 +: REGW];
    assign w_rs1   = bus.instr[15 +: REGW];
    assign w_rs2   = bus.instr[20 +: REGW];
    assign w_imm_i = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    assign w_imm_s = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign w_imm_b = {{(XLEN-12){bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                      bus.instr[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-32){bus.instr[31]}}, bus.instr[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-20){bus.instr[31]}}, bus.instr[19:12], bus.instr[20],
                      bus.instr[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction (next-state payload)
    // ------------------------------------------------------------------
    logic [3:0]      op_d;
    logic [2:0]      opb_d;
    logic            sela_d, selb_d, we_d, ill_d, rs1u_d, rs2u_d;
    logic [XLEN-1:0] imm_d;
    logic            w_writes, w_legal;

    always_comb begin
        op_d     = '0;
        opb_d    = '0;
        sela_d   = 1'b1;
        selb_d   = 1'b0;
        imm_d    = '0;
        rs1u_d   = 1'b0;
        rs2u_d   = 1'b0;
        w_writes = 1'b0;
        w_legal  = 1'b1;
        case (w_opc)
            OPC_LUI: begin
                op_d = OP_SIU; sela_d = 1'b0; imm_d = w_imm_u; w_writes = 1'b1;
            end
            OPC_AUIPC: begin
                op_d = OP_AIU; sela_d = 1'b0; imm_d = w_imm_u; w_writes = 1'b1;
            end
            OPC_JAL: begin
                op_d = OP_ADD; opb_d = BR_JMP; imm_d = w_imm_j; w_writes = 1'b1;
            end
            OPC_JALR: begin
                op_d = OP_ADD; opb_d = BR_JMP; imm_d = w_imm_i; w_writes = 1'b1;
                rs1u_d = 1'b1;
                if (w_f3 != 3'b000) w_legal = 1'b0;
            end
            OPC_BRANCH: begin
                selb_d = 1'b1; imm_d = w_imm_b; rs1u_d = 1'b1; rs2u_d = 1'b1;
                case (w_f3)
                    3'b000:  begin op_d = OP_SUB; opb_d = BR_ZER; end
                    3'b001:  begin op_d = OP_SUB; opb_d = BR_NZR; end
                    3'b100:  begin op_d = OP_SLT; opb_d = BR_DAT; end
                    3'b101:  begin op_d = OP_SLT; opb_d = BR_NDT; end
                    3'b110:  begin op_d = OP_SLU; opb_d = BR_DAT; end
                    3'b111:  begin op_d = OP_SLU; opb_d = BR_NDT; end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                op_d = OP_ADD; imm_d = w_imm_i; w_writes = 1'b1; rs1u_d = 1'b1;
                if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_legal = 1'b0;
            end
            OPC_STORE: begin
                op_d = OP_ADD; selb_d = 1'b1; imm_d = w_imm_s;
                rs1u_d = 1'b1; rs2u_d = 1'b1;
                if (w_f3 >= 3'b011) w_legal = 1'b0;
            end
            OPC_ARITHI: begin
                // Only shifts carry a funct7; elsewhere those bits are immediate.
                op_d = alu_op(w_f3, (w_f3 == 3'b101) && (w_f7 == F7_ALT));
                imm_d = w_imm_i; w_writes = 1'b1; rs1u_d = 1'b1;
                if ((w_f3 == 3'b001 && w_f7 != 7'b0) ||
                    (w_f3 == 3'b101 && w_f7 != 7'b0 && w_f7 != F7_ALT))
                    w_legal = 1'b0;
            end
            OPC_ARITHR: begin
                op_d = alu_op(w_f3, w_f7 == F7_ALT);
                selb_d = 1'b1; w_writes = 1'b1; rs1u_d = 1'b1; rs2u_d = 1'b1;
                if (!(w_f7 == 7'b0 ||
                      (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                    w_legal = 1'b0;
            end
            default: w_legal = 1'b0;
        endcase

        // Register indices beyond the implemented file (e.g. RV32E)
        if (rs1u_d   && {{(32-REGW){1'b0}}, w_rs1} >= NREG_U) w_legal = 1'b0;
        if (rs2u_d   && {{(32-REGW){1'b0}}, w_rs2} >= NREG_U) w_legal = 1'b0;
        if (w_writes && {{(32-REGW){1'b0}}, w_rd}  >= NREG_U) w_legal = 1'b0;

        ill_d = !w_legal;
        if (ill_d) begin
            op_d  = '0;
            opb_d = '0;
        end
        we_d = w_writes && w_legal && (w_rd != '0);
    end

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    logic            held_q, held_d;
    logic [3:0]      op_q;
    logic [2:0]      opb_q;
    logic            sela_q, selb_q, we_q, ill_q, rs1u_q, rs2u_q;
    logic [REGW-1:0] rd_q, rs1_q, rs2_q;
    logic [XLEN-1:0] imm_q;

    logic            w_hazard, w_out_valid, w_in_ready, w_accept, w_issue;

    assign w_out_valid = held_q && !w_hazard;
    assign w_issue     = w_out_valid && bus.out_ready;
    assign w_in_ready  = !bus.flush && (!held_q || w_issue);
    assign w_accept    = bus.in_valid && w_in_ready;

    always_comb begin
        held_d = held_q;
        if (bus.flush)    held_d = 1'b0;
        else if (w_accept) held_d = 1'b1;
        else if (w_issue)  held_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= 1'b0;
            op_q   <= '0;
            opb_q  <= '0;
            sela_q <= 1'b0;
            selb_q <= 1'b0;
            we_q   <= 1'b0;
            ill_q  <= 1'b0;
            rs1u_q <= 1'b0;
            rs2u_q <= 1'b0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            imm_q  <= '0;
        end else begin
            held_q <= held_d;
            if (w_accept) begin
                op_q   <= op_d;
                opb_q  <= opb_d;
                sela_q <= sela_d;
                selb_q <= selb_d;
                we_q   <= we_d;
                ill_q  <= ill_d;
                rs1u_q <= rs1u_d;
                rs2u_q <= rs2u_d;
                rd_q   <= w_rd;
                rs1_q  <= w_rs1;
                rs2_q  <= w_rs2;
                imm_q  <= imm_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: one pending-write counter per architectural register.
    // w_eff is the count the hazard check sees (bypass-adjusted if enabled).
    // ------------------------------------------------------------------
    logic [SB_CNT_W-1:0] w_eff [NSLOT];

    for (genvar r = 0; r < NSLOT; r++) begin : g_sb
        if (r >= 1 && r < NREG) begin : g_trk
            logic [SB_CNT_W-1:0] cnt_q;
            logic                w_inc, w_dec;

            assign w_inc = w_issue && we_q && (rd_q == REGW'(r));
            assign w_dec = bus.wb_valid && (bus.wb_rd == REGW'(r));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (w_inc && !w_dec) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (w_dec && !w_inc && cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end

`ifdef DECODE_WB_BYPASS_EN
            assign w_eff[r] = (w_dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
`else
            assign w_eff[r] = cnt_q;
`endif
        end else begin : g_none
            assign w_eff[r] = '0;
        end
    end

    // Illegal instructions never wait; saturated rd would overflow on issue.
    assign w_hazard = !ill_q &&
                      ((rs1u_q && rs1_q != '0 && w_eff[rs1_q] != '0) ||
                       (rs2u_q && rs2_q != '0 && w_eff[rs2_q] != '0) ||
                       (we_q   && w_eff[rd_q] == CNT_MAX));

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_op      = op_q;
    assign bus.out_op_b    = opb_q;
    assign bus.out_sela    = sela_q;
    assign bus.out_selb    = selb_q;
    assign bus.out_we      = we_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_rs1     = rs1_q;
    assign bus.out_rs2     = rs2_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_illegal = ill_q;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage: directed scenarios
//                followed by randomized traffic, compared every cycle against
//                an instruction-level reference model with a scoreboard.
//                Honours DECODE_WB_BYPASS_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    localparam int SB_MAX = 3;
`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  opb;
        logic        sela;
        logic        selb;
        logic        we;
        logic        ill;
        logic        rs1u;
        logic        rs2u;
        logic [31:0] imm;
    } dec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .REGW(5)) bus ();

    decode_stage #(.XLEN(32), .NREG(32), .REGW(5), .SB_CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    bit          m_held;
    logic [31:0] m_instr;
    int          m_cnt [32];
    logic [4:0]  m_retq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction-level reference decode
    function automatic dec_t model_decode(input logic [31:0] w);
        dec_t        d;
        bit          writes, legal;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [3:0]  base [8];
        logic [12:0] bimm;
        logic [20:0] jimm;
        base = '{4'd1, 4'd3, 4'd7, 4'd6, 4'd10, 4'd4, 4'd8, 4'd9};
        f3 = w[14:12];
        f7 = w[31:25];
        bimm = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        jimm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        d = '0;
        d.sela = 1'b1;
        writes = 1'b0;
        legal = 1'b1;
        case (w[6:0])
            7'h37: begin d.op = 11; d.sela = 0; d.imm = {w[31:12], 12'h0}; writes = 1; end
            7'h17: begin d.op = 12; d.sela = 0; d.imm = {w[31:12], 12'h0}; writes = 1; end
            7'h6F: begin d.op = 1; d.opb = 5; d.imm = 32'($signed(jimm)); writes = 1; end
            7'h67: begin
                d.op = 1; d.opb = 5; d.imm = 32'($signed(w[31:20])); writes = 1;
                d.rs1u = 1; legal = (f3 == 0);
            end
            7'h63: begin
                d.selb = 1; d.rs1u = 1; d.rs2u = 1; d.imm = 32'($signed(bimm));
                legal = !(f3 == 2 || f3 == 3);
                d.op  = (f3 < 2) ? 4'd2 : (f3 < 6) ? 4'd7 : 4'd6;
                d.opb = (f3 == 0) ? 3'd1 : (f3 == 1) ? 3'd2 : (f3[0] ? 3'd4 : 3'd3);
            end
            7'h03: begin
                d.op = 1; d.imm = 32'($signed(w[31:20])); writes = 1; d.rs1u = 1;
                legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'h23: begin
                d.op = 1; d.selb = 1; d.rs1u = 1; d.rs2u = 1;
                d.imm = 32'($signed({w[31:25], w[11:7]}));
                legal = (f3 < 3);
            end
            7'h13: begin
                d.imm = 32'($signed(w[31:20])); writes = 1; d.rs1u = 1;
                d.op = base[f3];
                if (f3 == 5 && f7 == 7'h20) d.op = 5;
                if (f3 == 1) legal = (f7 == 0);
                if (f3 == 5) legal = (f7 == 0 || f7 == 7'h20);
            end
            7'h33: begin
                d.selb = 1; writes = 1; d.rs1u = 1; d.rs2u = 1;
                d.op = base[f3];
                if (f7 == 7'h20 && f3 == 0) d.op = 2;
                if (f7 == 7'h20 && f3 == 5) d.op = 5;
                legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            end
            default: legal = 1'b0;
        endcase
        if (d.rs1u && int'(w[19:15]) >= 32) legal = 1'b0;
        if (d.rs2u && int'(w[24:20]) >= 32) legal = 1'b0;
        if (writes && int'(w[11:7]) >= 32) legal = 1'b0;
        d.ill = !legal;
        if (!legal) begin d.op = 0; d.opb = 0; end
        d.we = writes && legal && (w[11:7] != 0);
        return d;
    endfunction

    function automatic int m_eff(input int r, input logic wv, input logic [4:0] wr);
        int c;
        c = m_cnt[r];
        if (BYP && wv && int'(wr) == r && r != 0 && c > 0) c = c - 1;
        return c;
    endfunction

    function automatic bit m_hazard(input dec_t d, input logic [31:0] w,
                                    input logic wv, input logic [4:0] wr);
        int rs1, rs2, rd;
        rs1 = int'(w[19:15]);
        rs2 = int'(w[24:20]);
        rd  = int'(w[11:7]);
        return !d.ill && ((d.rs1u && rs1 != 0 && m_eff(rs1, wv, wr) != 0) ||
                          (d.rs2u && rs2 != 0 && m_eff(rs2, wv, wr) != 0) ||
                          (d.we && m_eff(rd, wv, wr) == SB_MAX));
    endfunction

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic iv, input logic [31:0] ins, input logic fl,
                        input logic ordy, input logic wv, input logic [4:0] wr);
        dec_t d;
        bit   exp_ov, exp_ir, issue, accept, inc, dec;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.instr     = ins;
        bus.flush     = fl;
        bus.out_ready = ordy;
        bus.wb_valid  = wv;
        bus.wb_rd     = wr;
        #1;
        d      = model_decode(m_instr);
        exp_ov = m_held && !m_hazard(d, m_instr, wv, wr);
        exp_ir = !fl && (!m_held || (exp_ov && ordy));
        check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        check("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        if (m_held) begin
            check("op", 32'(bus.out_op), 32'(d.op));
            check("op_b", 32'(bus.out_op_b), 32'(d.opb));
            check("sela", 32'(bus.out_sela), 32'(d.sela));
            check("selb", 32'(bus.out_selb), 32'(d.selb));
            check("we", 32'(bus.out_we), 32'(d.we));
            check("illegal", 32'(bus.out_illegal), 32'(d.ill));
            check("imm", bus.out_imm, d.imm);
            check("rd", 32'(bus.out_rd), 32'(m_instr[11:7]));
            check("rs1", 32'(bus.out_rs1), 32'(m_instr[19:15]));
            check("rs2", 32'(bus.out_rs2), 32'(m_instr[24:20]));
        end
        issue  = exp_ov && ordy;
        accept = iv && exp_ir;
        for (int r = 1; r < 32; r++) begin
            inc = issue && d.we && (int'(m_instr[11:7]) == r);
            dec = wv && (int'(wr) == r);
            if (inc && !dec) m_cnt[r] = m_cnt[r] + 1;
            else if (dec && !inc && m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
        end
        if (issue && d.we) m_retq.push_back(m_instr[11:7]);
        if (fl) m_held = 1'b0;
        else if (accept) m_held = 1'b1;
        else if (issue) m_held = 1'b0;
        if (accept) m_instr = ins;
    endtask

    task automatic model_reset();
        m_held = 1'b0;
        m_instr = '0;
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opcs [9];
        int          k;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        w = $urandom;
        k = $urandom_range(0, 10);
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        if (k < 9) begin
            w[6:0] = opcs[k];
            if (k == 3 && $urandom_range(0, 3) != 0) w[14:12] = 3'b000;
            if (k >= 7) begin
                case ($urandom_range(0, 4))
                    0, 1:    w[31:25] = 7'h00;
                    2:       w[31:25] = 7'h20;
                    default: w[31:25] = 7'($urandom);
                endcase
            end
        end
        return w;
    endfunction

    localparam logic [31:0] I_ADDI_X5  = 32'h0070_0293;
    localparam logic [31:0] I_ADD_X6   = 32'h0052_8333;
    localparam logic [31:0] I_BLTU     = 32'hFE20_EEE3;
    localparam logic [31:0] I_JAL      = 32'h0080_00EF;
    localparam logic [31:0] I_BADOPC   = 32'h0000_007F;
    localparam logic [31:0] I_SRAI_BAD = 32'h0230_D113;
    localparam logic [31:0] I_ADD_X3   = 32'h0021_01B3;

    initial begin
        logic       iv, fl, ordy, wv;
        logic [4:0] wr;
        bus.in_valid = 0; bus.instr = '0; bus.flush = 0;
        bus.out_ready = 0; bus.wb_valid = 0; bus.wb_rd = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_op", 32'(bus.out_op), 32'd0);
        check("rst_imm", bus.out_imm, 32'd0);
        check("rst_we", 32'(bus.out_we), 32'd0);
        check("rst_sela", 32'(bus.out_sela), 32'd0);
        rst_n = 1'b1;

        // ADDI x5,x0,7 then dependent ADD x6,x5,x5
        step(1, I_ADDI_X5, 0, 1, 0, 0);
        step(1, I_ADD_X6, 0, 1, 0, 0);
        check("addi_valid", 32'(bus.out_valid), 32'd1);
        check("addi_op", 32'(bus.out_op), 32'd1);
        check("addi_selb", 32'(bus.out_selb), 32'd0);
        check("addi_imm", bus.out_imm, 32'd7);
        check("addi_we", 32'(bus.out_we), 32'd1);
        check("addi_rd", 32'(bus.out_rd), 32'd5);
        step(0, 0, 0, 1, 0, 0);
        check("raw_stall", 32'(bus.out_valid), 32'd0);
        step(0, 0, 0, 1, 0, 0);
        check("raw_stall2", 32'(bus.out_valid), 32'd0);
        step(0, 0, 0, 1, 1, 5);
        check("raw_wb_cycle", 32'(bus.out_valid), 32'(BYP));
        step(0, 0, 0, 1, 0, 0);
        check("raw_after_wb", 32'(bus.out_valid), 32'(!BYP));
        step(0, 0, 0, 1, 0, 0);

        // BLTU held under back-pressure, then flushed; then JAL
        step(1, I_BLTU, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, I_JAL, 0, 0, 0, 0);
            check("bltu_valid", 32'(bus.out_valid), 32'd1);
            check("bltu_in_ready", 32'(bus.in_ready), 32'd0);
            check("bltu_op", 32'(bus.out_op), 32'd6);
            check("bltu_opb", 32'(bus.out_op_b), 32'd3);
            check("bltu_selb", 32'(bus.out_selb), 32'd1);
            check("bltu_we", 32'(bus.out_we), 32'd0);
            check("bltu_imm", bus.out_imm, 32'hFFFF_FFFC);
        end
        step(1, I_JAL, 1, 0, 0, 0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd0);
        step(0, 0, 0, 1, 0, 0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        step(1, I_JAL, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("jal_valid", 32'(bus.out_valid), 32'd1);
        check("jal_opb", 32'(bus.out_op_b), 32'd5);
        check("jal_imm", bus.out_imm, 32'd8);
        step(0, 0, 0, 1, 1, 1);

        // Illegal instructions: no stall, no scoreboard increment
        step(1, I_BADOPC, 0, 1, 0, 0);
        step(1, I_SRAI_BAD, 0, 1, 0, 0);
        check("badopc_ill", 32'(bus.out_illegal), 32'd1);
        check("badopc_op", 32'(bus.out_op), 32'd0);
        check("badopc_valid", 32'(bus.out_valid), 32'd1);
        step(1, I_ADD_X3, 0, 1, 0, 0);
        check("srai_ill", 32'(bus.out_illegal), 32'd1);
        check("srai_op", 32'(bus.out_op), 32'd0);
        check("srai_we", 32'(bus.out_we), 32'd0);
        check("srai_valid", 32'(bus.out_valid), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        check("after_ill_valid", 32'(bus.out_valid), 32'd1);

        // Reset with HELD=1 and CNT[x5]=2
        step(1, I_ADDI_X5, 0, 1, 0, 0);
        step(1, I_ADDI_X5, 0, 1, 0, 0);
        step(1, I_ADD_X6, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("pre_rst_stall", 32'(bus.out_valid), 32'd0);
        #2;
        bus.in_valid = 0; bus.flush = 0; bus.out_ready = 0; bus.wb_valid = 0;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, I_ADD_X6, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("post_rst_no_stall", 32'(bus.out_valid), 32'd1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            wv   = 1'b0;
            wr   = 5'($urandom_range(0, 31));
            if (m_retq.size() > 0 && $urandom_range(0, 2) == 0) begin
                wv = 1'b1;
                wr = m_retq.pop_front();
            end else if ($urandom_range(0, 15) == 0) begin
                wv = 1'b1;
                wr = 5'($urandom_range(0, 7));
            end
            step(iv, rand_instr(), fl, ordy, wv, wr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered instruction-decode stage for the RV32I core. Replaces the purely combinational controller path with a one-entry pipeline register, valid/ready handshakes on both sides, full immediate generation and illegal-instruction detection.
- Adds a per-register pending-write scoreboard that holds back read-after-write hazards until the corresponding writeback retires.
- Sits between fetch and execute. Writeback feeds retire events back into it.

Parameters:
- XLEN, 32, datapath and immediate width.
- NREG, 32, architectural register count (16 for RV32E); registers at or above NREG are flagged illegal.
- REGW, 5, register index width.
- SB_CNT_W, 2, width of each scoreboard counter, giving at most 2^SB_CNT_W-1 in-flight writes per register.

Ports:
- CLK in 1: rising-edge clock.
- RST_N in 1: asynchronous, active-low reset.
- IN_VALID in 1: fetch offers INSTR.
- IN_READY out 1: stage accepts INSTR this cycle.
- INSTR in 32: raw instruction.
- FLUSH in 1: discard the held instruction.
- OUT_VALID out 1: decoded instruction is available and hazard-free.
- OUT_READY in 1: execute accepts the instruction.
- OUT_OP out 4: ALU op (ADD=1 SUB=2 SLL=3 SRL=4 SRA=5 SLU=6 SLT=7 OR=8 AND=9 XOR=10 SIU=11 AIU=12, 0=none).
- OUT_OP_B out 3: branch op (ZER=1 NZR=2 DAT=3 NDT=4 JMP=5, 0=none).
- OUT_SELA out 1: 1 selects rs1, 0 selects PC.
- OUT_SELB out 1: 1 selects rs2, 0 selects immediate.
- OUT_WE out 1: register write enable.
- OUT_RD, OUT_RS1, OUT_RS2 out REGW each: register indices.
- OUT_IMM out XLEN: sign-extended immediate (I/S/B/U/J format by opcode).
- OUT_ILLEGAL out 1: held instruction is illegal.
- WB_VALID in 1: a write retires this cycle.
- WB_RD in REGW: register written by the retiring write.

Behaviour:
- Reset (RST_N low, asynchronous): OUT_VALID=0; all registered outputs 0; all scoreboard counters 0. IN_READY is combinational and reads 1 after reset.

Handshake and pipeline register:
- Internal HELD flag marks the one-entry register as occupied.
- IN_READY = !HELD | (OUT_VALID & OUT_READY).
- Accept (IN_VALID & IN_READY): decode INSTR into the register and set HELD. Latency is one cycle: accepted in cycle N, OUT_VALID can be high in cycle N+1.
- Issue = OUT_VALID & OUT_READY. Issue without a simultaneous accept clears HELD.
- OUT_VALID = HELD & !HAZARD.
- Outputs are stable while OUT_VALID & !OUT_READY.

Flush:
- FLUSH clears HELD next edge, has priority over accept, and forces IN_READY=0 that cycle.
- The scoreboard is not touched, because the held instruction has not issued.

Decode:
- SELA=0 for LUI/AUIPC.
- SELB=1 for BTYPE, STORES and ARITHM_R.
- WE=0 for STORES, BTYPE, illegal instructions, and whenever rd=0.
- LUI -> SIU; AUIPC -> AIU.
- JAL/JALR -> OP=ADD, OP_B=JMP.
- Loads/stores -> OP=ADD.
- BTYPE:
  - BEQ/BNE -> SUB; BLT/BGE -> SLT; BLTU/BGEU -> SLU.
  - OP_B: BEQ -> ZER, BNE -> NZR, BLT/BLTU -> DAT, BGE/BGEU -> NDT.
- ARITHM_I/ARITHM_R use funct3:
  - funct7=0100000 selects SUB (R-type only) or SRA.
- OP_B=0 for every non-branch, non-jump instruction.

Illegal:
- Unknown opcode.
- BTYPE funct3 010/011.
- JALR funct3≠0.
- Load funct3 011/110/111.
- Store funct3 ≥011.
- R-type funct7 outside {0000000, 0100000}, or 0100000 with funct3 ∉ {000, 101}.
- Shift-immediate with a bad funct7.
- Any used register index ≥ NREG.
- Effect: ILLEGAL=1, OP=0, OP_B=0, WE=0. An illegal instruction never stalls on hazards.

Scoreboard:
- One counter per register 1..NREG-1; x0 is never tracked.
- Issue with WE=1: CNT[rd]+1.
- WB_VALID with WB_RD≠0: CNT[WB_RD]-1.
- Increment and decrement to the same register in the same cycle leave it unchanged.
- Decrement at 0 is ignored, and the counter stays 0.

Hazard:
- rs1 used (all opcodes except LUI/AUIPC/JAL) and rs1≠0 and CNT[rs1]≠0; or
- rs2 used (BTYPE/STORES/ARITHM_R) and rs2≠0 and CNT[rs2]≠0; or
- WE=1 and CNT[rd] is saturated.
- Hazard evaluation uses registered counts, so a writeback unblocks the stalled instruction one cycle later.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: the hazard check uses CNT minus a same-cycle WB_VALID match, so a writeback to a stalled source raises OUT_VALID in the same cycle.
- Undefined: one-cycle penalty as described under Behaviour.

Test Plan:
- Reset mid-stream with HELD=1 and CNT[x5]=2 -> next cycle OUT_VALID=0, IN_READY=1, all counters 0.
- Accept ADDI x5,x0,7 (0x00700293), OUT_READY=1 -> OUT_VALID in cycle N+1 with OP=1, SELB=0, IMM=7, WE=1, RD=5; CNT[5] becomes 1.
- Then ADD x6,x5,x5 -> OUT_VALID held 0 until WB_VALID with WB_RD=5; OUT_VALID=1 one cycle later (same cycle with DECODE_WB_BYPASS_EN).
- BLTU x1,x2,-4 -> OP=6, OP_B=3, SELB=1, WE=0, IMM=0xFFFFFFFC; JAL x1,+8 -> OP_B=5, IMM=8.
- OUT_READY=0 for 3 cycles with a new IN_VALID -> IN_READY=0 and outputs stable; FLUSH -> OUT_VALID=0 next cycle, counters unchanged.
- Opcode 0x7F, or SRAI with funct7=0000001 -> ILLEGAL=1, OP=0, WE=0, no stall, no scoreboard increment on issue.
